// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: RAW operand-forward selects, load-use / no-forward stall control, saturating perf counters.
// Latency: sel_src, hazard_stall and fwd_hit are combinational; FSM state and counters update on the next clk edge.
// Backpressure: accepts none; hazard_stall is the freeze request this block raises toward PC/IF/ID.

`ifndef FORW_SEL_FROM_EXE
`define FORW_SEL_FROM_EXE 2'b01
`endif
`ifndef FORW_SEL_FROM_MEM
`define FORW_SEL_FROM_MEM 2'b10
`endif

module fwd_hazard_unit #(
  parameter int REG_W    = 4,
  parameter int NUM_SRC  = 3,
  parameter int LOAD_LAT = 1,   // total stall cycles per load-use hazard, 1..15
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,          // synchronous, active-low
  input  logic                     fwd_en,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     exe_wb_en,
  input  logic                     exe_mem_rd,
  input  logic [REG_W-1:0]         exe_dst,
  input  logic                     mem_wb_en,
  input  logic [REG_W-1:0]         mem_dst,
  output logic [2*NUM_SRC-1:0]     sel_src,
  output logic                     hazard_stall,
  output logic                     fwd_hit,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         fwd_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } state_t;

  // LD_WAIT covers the stall cycles after the first one, so it is loaded
  // with LOAD_LAT-2 and leaves when it reaches zero.
  localparam logic [3:0]       WCNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [NUM_SRC-1:0] match_exe;
  logic [NUM_SRC-1:0] match_mem;
  logic               load_use;
  logic               raw_nofwd;
  logic               fsm_stall;

  state_t             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d;

  // Compare every live source operand against both in-flight writers.
  always_comb begin
    match_exe = '0;
    match_mem = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      match_exe[i] = id_valid & id_src_used[i] & exe_wb_en &
                     (exe_dst == id_src[i*REG_W +: REG_W]);
      match_mem[i] = id_valid & id_src_used[i] & mem_wb_en &
                     (mem_dst == id_src[i*REG_W +: REG_W]);
    end
  end

  // Operand mux selects: EXE holds the younger writer so it wins, except a
  // load whose data does not exist yet; then an older MEM match may still apply.
  always_comb begin
    sel_src = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_en) begin
        if (match_exe[i] && !exe_mem_rd) begin
          sel_src[2*i +: 2] = `FORW_SEL_FROM_EXE;
        end else if (match_mem[i]) begin
          sel_src[2*i +: 2] = `FORW_SEL_FROM_MEM;
        end
      end
    end
  end

  assign fwd_hit   = |sel_src;
  assign load_use  = fwd_en & exe_mem_rd & (|match_exe);
  assign raw_nofwd = !fwd_en & (|(match_exe | match_mem));

  // The FSM contribution is suppressed by flush and by reset in the same
  // cycle, so an abandoned load stall never leaks a stray bubble.
  assign fsm_stall = rst & !flush &
                     (((state_q == IDLE) & load_use) | (state_q == LD_WAIT));

  assign hazard_stall = raw_nofwd | fsm_stall;

  // Load-use wait sequencing; LOAD_LAT==1 never leaves IDLE because the
  // single bubble lets the load reach MEM and forward from there.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (load_use && !flush && (LOAD_LAT > 1)) begin
          state_d = LD_WAIT;
          wcnt_d  = WCNT_INIT;
        end
      end
      LD_WAIT: begin
        if (flush || (wcnt_q == 4'd0)) begin
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (hazard_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (fwd_hit && (fwd_cnt_q != CNT_MAX)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed stimulus with a cycle-level reference model and literal spot checks.
// Latency: model compares combinational outputs and counters on every falling edge.
// Backpressure: not applicable; the bench drives every input directly.

module tb_fwd_hazard_unit;

  localparam int REG_W   = 4;
  localparam int NUM_SRC = 3;
  localparam int LL      = 3;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;
  localparam logic [1:0] SEL_EXE = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic                     clk;
  logic                     rst;
  logic                     fwd_en;
  logic                     flush;
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic                     exe_wb_en;
  logic                     exe_mem_rd;
  logic [REG_W-1:0]         exe_dst;
  logic                     mem_wb_en;
  logic [REG_W-1:0]         mem_dst;
  logic [2*NUM_SRC-1:0]     sel_src;
  logic                     hazard_stall;
  logic                     fwd_hit;
  logic [CW-1:0]            stall_cnt;
  logic [CW-1:0]            fwd_cnt;

  fwd_hazard_unit #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(LL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .id_valid(id_valid),
    .id_src(id_src), .id_src_used(id_src_used), .exe_wb_en(exe_wb_en),
    .exe_mem_rd(exe_mem_rd), .exe_dst(exe_dst), .mem_wb_en(mem_wb_en),
    .mem_dst(mem_dst), .sel_src(sel_src), .hazard_stall(hazard_stall),
    .fwd_hit(fwd_hit), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       fen;
    logic       vld;
    logic [3:0] s2;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [2:0] used;
    logic       ewb;
    logic       erd;
    logic [3:0] edst;
    logic       mwb;
    logic [3:0] mdst;
  } vec_t;

  localparam vec_t V_IDLE    = '{1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0};
  localparam vec_t V_FWD_EXE = '{1'b1, 1'b1, 4'd0, 4'd0, 4'd3, 3'b001, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3};
  localparam vec_t V_MEM2    = '{1'b1, 1'b1, 4'd5, 4'd5, 4'd0, 3'b110, 1'b1, 1'b0, 4'd2, 1'b1, 4'd5};
  localparam vec_t V_MEM1    = '{1'b1, 1'b1, 4'd5, 4'd5, 4'd0, 3'b010, 1'b1, 1'b0, 4'd2, 1'b1, 4'd5};
  localparam vec_t V_LOAD7   = '{1'b1, 1'b1, 4'd0, 4'd0, 4'd7, 3'b001, 1'b1, 1'b1, 4'd7, 1'b0, 4'd0};
  localparam vec_t V_NOFWD   = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 3'b001, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1};

  localparam int NV = 8;
  localparam vec_t TBL [NV] = '{
    '{1'b1, 1'b1, 4'd0, 4'd0, 4'd15, 3'b001, 1'b1, 1'b0, 4'd15, 1'b0, 4'd0},  // PC reg forwards like any other
    '{1'b1, 1'b1, 4'd0, 4'd0, 4'd4,  3'b001, 1'b1, 1'b1, 4'd4,  1'b1, 4'd4},  // load + MEM same reg
    '{1'b1, 1'b1, 4'd6, 4'd0, 4'd0,  3'b011, 1'b1, 1'b0, 4'd6,  1'b0, 4'd0},  // matching source unused
    '{1'b1, 1'b1, 4'd2, 4'd9, 4'd2,  3'b111, 1'b1, 1'b0, 4'd2,  1'b1, 4'd9},  // mixed EXE/MEM selects
    '{1'b0, 1'b1, 4'd0, 4'd0, 4'd7,  3'b001, 1'b1, 1'b1, 4'd7,  1'b0, 4'd0},  // no-forward mode vs load
    '{1'b1, 1'b0, 4'd0, 4'd0, 4'd3,  3'b001, 1'b1, 1'b0, 4'd3,  1'b1, 4'd3},  // bubble in ID
    '{1'b1, 1'b1, 4'd0, 4'd8, 4'd0,  3'b010, 1'b1, 1'b0, 4'd1,  1'b1, 4'd8},  // MEM only
    '{1'b1, 1'b1, 4'd0, 4'd0, 4'd5,  3'b001, 1'b0, 1'b0, 4'd5,  1'b1, 4'd5}   // EXE not writing
  };

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    fwd_en      = v.fen;
    id_valid    = v.vld;
    id_src      = {v.s2, v.s1, v.s0};
    id_src_used = v.used;
    exe_wb_en   = v.ewb;
    exe_mem_rd  = v.erd;
    exe_dst     = v.edst;
    mem_wb_en   = v.mwb;
    mem_dst     = v.mdst;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: stall_left counts remaining load-use stall cycles.
  int         stall_left = 0;
  int         m_stall    = 0;
  int         m_fwd      = 0;
  bit         cnt_known  = 1'b0;
  logic [5:0] e_sel;
  logic       e_stall;
  logic       e_hit;
  logic       e_lu;

  always @(negedge clk) begin
    logic       me, mm, any_e, any_m;
    logic [3:0] s;
    e_sel = '0;
    any_e = 1'b0;
    any_m = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s  = id_src[i*REG_W +: REG_W];
      me = id_valid && id_src_used[i] && exe_wb_en && (exe_dst == s);
      mm = id_valid && id_src_used[i] && mem_wb_en && (mem_dst == s);
      any_e = any_e | me;
      any_m = any_m | mm;
      if (fwd_en) begin
        if (me && !exe_mem_rd)  e_sel[2*i +: 2] = SEL_EXE;
        else if (mm)            e_sel[2*i +: 2] = SEL_MEM;
      end
    end
    e_hit   = (e_sel != 6'd0);
    e_lu    = fwd_en && exe_mem_rd && any_e;
    e_stall = (!fwd_en && (any_e || any_m)) ||
              (rst && !flush && ((stall_left > 0) || e_lu));
    check("m_sel_src", 32'(sel_src), 32'(e_sel));
    check("m_hazard_stall", 32'(hazard_stall), 32'(e_stall));
    check("m_fwd_hit", 32'(fwd_hit), 32'(e_hit));
    if (cnt_known) begin
      check("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("m_fwd_cnt", 32'(fwd_cnt), 32'(m_fwd));
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      stall_left = 0;
      m_stall    = 0;
      m_fwd      = 0;
      cnt_known  = 1'b1;
    end else begin
      if (e_stall && m_stall < CMAX) m_stall = m_stall + 1;
      if (e_hit && m_fwd < CMAX)     m_fwd   = m_fwd + 1;
      if (stall_left > 0)            stall_left = flush ? 0 : stall_left - 1;
      else if (e_lu && !flush)       stall_left = LL - 1;
    end
  end

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    apply(V_IDLE);
    cyc(); cyc();
    #5;
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_fwd_cnt", 32'(fwd_cnt), 0);
    check("rst_hazard", 32'(hazard_stall), 0);

    // EXE beats MEM for the same register
    cyc(); rst = 1'b1; apply(V_FWD_EXE); #5;
    check("t1_sel", 32'(sel_src), 32'h01);
    check("t1_hit", 32'(fwd_hit), 1);
    check("t1_stall", 32'(hazard_stall), 0);
    check("t1_fcnt0", 32'(fwd_cnt), 0);
    cyc(); apply(V_IDLE); #5;
    check("t1_fcnt1", 32'(fwd_cnt), 1);

    // two sources from MEM, then one dropped by its used flag
    cyc(); apply(V_MEM2); #5;
    check("t2_sel", 32'(sel_src), 32'h28);
    cyc(); apply(V_MEM1); #5;
    check("t2_sel_unused", 32'(sel_src), 32'h08);
    check("t2_fcnt", 32'(fwd_cnt), 2);

    // load-use: three stall cycles
    cyc(); apply(V_LOAD7); #5;
    check("t3_stall0", 32'(hazard_stall), 1);
    check("t3_sel", 32'(sel_src), 0);
    check("t3_hit", 32'(fwd_hit), 0);
    repeat (2) begin
      cyc(); #5;
      check("t3_stall_wait", 32'(hazard_stall), 1);
    end
    cyc(); apply(V_IDLE); #5;
    check("t3_stall_end", 32'(hazard_stall), 0);
    check("t3_scnt", 32'(stall_cnt), 3);

    // flush in the second stall cycle
    cyc(); apply(V_LOAD7); #5;
    check("t4_stall0", 32'(hazard_stall), 1);
    cyc(); flush = 1'b1; #5;
    check("t4_flush", 32'(hazard_stall), 0);
    cyc(); flush = 1'b0; apply(V_IDLE); #5;
    check("t4_after", 32'(hazard_stall), 0);
    check("t4_scnt", 32'(stall_cnt), 4);

    // forwarding disabled
    cyc(); apply(V_NOFWD); #5;
    check("t5_sel", 32'(sel_src), 0);
    check("t5_stall", 32'(hazard_stall), 1);
    check("t5_hit", 32'(fwd_hit), 0);
    cyc(); id_valid = 1'b0; #5;
    check("t5_invalid", 32'(hazard_stall), 0);

    // assorted vectors, checked by the model only
    for (int k = 0; k < NV; k++) begin
      cyc(); apply(TBL[k]);
    end
    cyc(); apply(V_IDLE);
    repeat (3) cyc();
    cyc(); apply(V_LOAD7); flush = 1'b1; #5;
    check("flush_idle", 32'(hazard_stall), 0);
    cyc(); apply(V_IDLE); flush = 1'b0; #5;
    check("flush_idle_next", 32'(hazard_stall), 0);

    // counter saturation
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1; apply(V_FWD_EXE);
    repeat (13) cyc();
    cyc(); apply(V_IDLE); #5;
    check("t6_fcnt14", 32'(fwd_cnt), 14);
    cyc(); apply(V_FWD_EXE);
    repeat (2) cyc();
    cyc(); apply(V_IDLE); #5;
    check("t6_fcnt_sat", 32'(fwd_cnt), CMAX);

    // reset in the middle of LD_WAIT
    cyc(); apply(V_LOAD7); #5;
    check("t6_ld0", 32'(hazard_stall), 1);
    cyc(); #5;
    check("t6_ld1", 32'(hazard_stall), 1);
    cyc(); rst = 1'b0; #5;
    check("t6_rst_cycle", 32'(hazard_stall), 0);
    cyc(); rst = 1'b1; apply(V_IDLE); #5;
    check("t6_post_stall", 32'(hazard_stall), 0);
    check("t6_post_scnt", 32'(stall_cnt), 0);
    check("t6_post_fcnt", 32'(fwd_cnt), 0);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
